// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: RX link-state controller for the 10G MAC (XGMII RX domain).
// Gates RX FIFO writes, aborts frames on fault, drives TX fault response.
//
// Ports:
//   clk_xgmii_rx, reset_xgmii_rx_n        clock, async active-low reset
//   status_local_fault_crx                local fault (registered)
//   status_remote_fault_crx               remote fault (registered)
//   rx_sof / rx_eof / rx_idle_col         per-word frame markers
//   int_clear                             clears sticky bits and counter
//   rx_enable, link_up                    link in UP state
//   rx_abort                              one-cycle errored-frame pulse
//   tx_send_rf, tx_send_idle              TX fault response
//   int_local_fault, int_remote_fault,
//   int_link_down                         sticky interrupt bits
//   fault_event_cnt                       saturating fault-onset count
module rx_link_ctrl #(
   parameter int HOLDOFF_CYCLES = 16,
   parameter int CNT_W          = 16
) (
   input  logic             clk_xgmii_rx,
   input  logic             reset_xgmii_rx_n,
   input  logic             status_local_fault_crx,
   input  logic             status_remote_fault_crx,
   input  logic             rx_sof,
   input  logic             rx_eof,
   input  logic             rx_idle_col,
   input  logic             int_clear,
   output logic             rx_enable,
   output logic             rx_abort,
   output logic             link_up,
   output logic             tx_send_rf,
   output logic             tx_send_idle,
   output logic             int_local_fault,
   output logic             int_remote_fault,
   output logic             int_link_down,
   output logic [CNT_W-1:0] fault_event_cnt
);

   typedef enum logic [1:0] {
      S_DOWN,
      S_HOLDOFF,
      S_WAIT_IDLE,
      S_UP
   } state_e;

   localparam logic [7:0] HLAST = 8'(HOLDOFF_CYCLES - 1);

   state_e           state_q, state_d;
   logic [7:0]       hcnt_q, hcnt_d;
   logic             in_frame_q, in_frame_d;
   logic             abort_q, abort_d;
   logic             lf_prev_q, rf_prev_q, flt_prev_q;
   logic             send_rf_q, send_idle_q;
   logic             int_lf_q, int_lf_d;
   logic             int_rf_q, int_rf_d;
   logic             int_ld_q, int_ld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_base;

   logic fault;
   logic lf_edge, rf_edge, flt_edge;
   logic ld_evt;

   assign fault    = status_local_fault_crx | status_remote_fault_crx;
   assign lf_edge  = status_local_fault_crx & ~lf_prev_q;
   assign rf_edge  = status_remote_fault_crx & ~rf_prev_q;
   assign flt_edge = fault & ~flt_prev_q;

   // SOF wins over EOF: an EOF/SOF word closes one frame and opens the next.
   always_comb begin
      in_frame_d = in_frame_q;
      if (rx_sof)
         in_frame_d = 1'b1;
      else if (rx_eof)
         in_frame_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      abort_d = 1'b0;
      ld_evt  = 1'b0;
      unique case (state_q)
         S_DOWN: begin
            if (!fault) begin
               state_d = S_HOLDOFF;
               hcnt_d  = '0;
            end
         end
         S_HOLDOFF: begin
            if (fault)
               state_d = S_DOWN;
            else if (hcnt_q == HLAST)
               state_d = S_WAIT_IDLE;
            else
               hcnt_d = hcnt_q + 8'd1;
         end
         S_WAIT_IDLE: begin
            // Only open the gate on an idle column outside any frame.
            if (fault)
               state_d = S_DOWN;
            else if (rx_idle_col && !in_frame_q && !rx_sof)
               state_d = S_UP;
         end
         S_UP: begin
            if (fault) begin
               state_d = S_DOWN;
               ld_evt  = 1'b1;
               abort_d = in_frame_q | rx_sof;
            end
         end
         default: state_d = S_DOWN;
      endcase
   end

   // A set event in the same cycle as int_clear leaves the bit set.
   always_comb begin
      int_lf_d = (int_clear ? 1'b0 : int_lf_q) | lf_edge;
      int_rf_d = (int_clear ? 1'b0 : int_rf_q) | rf_edge;
      int_ld_d = (int_clear ? 1'b0 : int_ld_q) | ld_evt;
      cnt_base = int_clear ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if (flt_edge && (cnt_base != {CNT_W{1'b1}}))
         cnt_d = cnt_base + 1'b1;
   end

   always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
      if (!reset_xgmii_rx_n) begin
         state_q     <= S_DOWN;
         hcnt_q      <= '0;
         in_frame_q  <= 1'b0;
         abort_q     <= 1'b0;
         lf_prev_q   <= 1'b0;
         rf_prev_q   <= 1'b0;
         flt_prev_q  <= 1'b0;
         send_rf_q   <= 1'b0;
         send_idle_q <= 1'b0;
         int_lf_q    <= 1'b0;
         int_rf_q    <= 1'b0;
         int_ld_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         in_frame_q  <= in_frame_d;
         abort_q     <= abort_d;
         lf_prev_q   <= status_local_fault_crx;
         rf_prev_q   <= status_remote_fault_crx;
         flt_prev_q  <= fault;
         send_rf_q   <= status_local_fault_crx;
         send_idle_q <= status_remote_fault_crx &
                        ~status_local_fault_crx;
         int_lf_q    <= int_lf_d;
         int_rf_q    <= int_rf_d;
         int_ld_q    <= int_ld_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rx_enable        = (state_q == S_UP);
   assign link_up          = (state_q == S_UP);
   assign rx_abort         = abort_q;
   assign tx_send_rf       = send_rf_q;
   assign tx_send_idle     = send_idle_q;
   assign int_local_fault  = int_lf_q;
   assign int_remote_fault = int_rf_q;
   assign int_link_down    = int_ld_q;
   assign fault_event_cnt  = cnt_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// tb_rx_link_ctrl: directed self-checking bench for rx_link_ctrl.
// Second instance with CNT_W=2 exercises counter saturation.
module tb_rx_link_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic loc = 1'b0, rem = 1'b0;
   logic sof = 1'b0, eof = 1'b0, idle = 1'b0, clr = 1'b0;

   logic        en, abrt, lup, srf, sidl, ilf, irf, ild;
   logic [15:0] cnt;
   logic        en2, abrt2, lup2, srf2, sidl2, ilf2, irf2, ild2;
   logic [1:0]  cnt2;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rx_link_ctrl #(.HOLDOFF_CYCLES(16), .CNT_W(16)) dut (
      .clk_xgmii_rx(clk), .reset_xgmii_rx_n(rst_n),
      .status_local_fault_crx(loc), .status_remote_fault_crx(rem),
      .rx_sof(sof), .rx_eof(eof), .rx_idle_col(idle),
      .int_clear(clr), .rx_enable(en), .rx_abort(abrt),
      .link_up(lup), .tx_send_rf(srf), .tx_send_idle(sidl),
      .int_local_fault(ilf), .int_remote_fault(irf),
      .int_link_down(ild), .fault_event_cnt(cnt)
   );

   rx_link_ctrl #(.HOLDOFF_CYCLES(16), .CNT_W(2)) dut2 (
      .clk_xgmii_rx(clk), .reset_xgmii_rx_n(rst_n),
      .status_local_fault_crx(loc), .status_remote_fault_crx(rem),
      .rx_sof(sof), .rx_eof(eof), .rx_idle_col(idle),
      .int_clear(clr), .rx_enable(en2), .rx_abort(abrt2),
      .link_up(lup2), .tx_send_rf(srf2), .tx_send_idle(sidl2),
      .int_local_fault(ilf2), .int_remote_fault(irf2),
      .int_link_down(ild2), .fault_event_cnt(cnt2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Outputs as a packed word: en,abrt,lup,srf,sidl,ilf,irf,ild
   function automatic logic [7:0] outs();
      return {en, abrt, lup, srf, sidl, ilf, irf, ild};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_chk++;
      if (outs() !== 8'h00 || cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_outs: got %b cnt %0d want 00000000 cnt 0",
                  outs(), cnt);
      end
      idle = 1'b1;
      rst_n = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         n_chk++;
         if (lup !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_holdoff cyc %0d: link_up got %b want 0",
                     i, lup);
         end
      end
      step();
      n_chk++;
      if (lup !== 1'b1 || en !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_linkup18: link_up %b rx_enable %b want 1 1",
                  lup, en);
      end
   endtask

   task automatic test_fault_abort();
      sof = 1'b1;
      step();
      sof = 1'b0;
      loc = 1'b1;
      step();
      n_chk++;
      if (outs() !== 8'b01010101 || cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL fault_abort: got %b cnt %0d want 01010101 cnt 1",
                  outs(), cnt);
      end
      step();
      n_chk++;
      if (abrt !== 1'b0 || en !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_width: rx_abort %b rx_enable %b want 0 0",
                  abrt, en);
      end
   endtask

   task automatic test_priority();
      rem = 1'b1;
      step();
      n_chk++;
      if (srf !== 1'b1 || sidl !== 1'b0 || irf !== 1'b1 ||
          cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL prio_both: rf %b idle %b irf %b cnt %0d want 1 0 1 1",
                  srf, sidl, irf, cnt);
      end
      loc = 1'b0;
      step();
      n_chk++;
      if (srf !== 1'b0 || sidl !== 1'b1 || cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL prio_remote: rf %b idle %b cnt %0d want 0 1 1",
                  srf, sidl, cnt);
      end
   endtask

   task automatic test_glitch();
      eof = 1'b1;
      rem = 1'b0;
      step();
      eof = 1'b0;
      repeat (10) step();
      rem = 1'b1;
      step();
      rem = 1'b0;
      n_chk++;
      if (lup !== 1'b0 || cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL glitch_onset: link_up %b cnt %0d want 0 2",
                  lup, cnt);
      end
      for (int i = 1; i <= 17; i++) begin
         step();
         n_chk++;
         if (lup !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_restart cyc %0d: link_up %b want 0",
                     i, lup);
         end
      end
      sof = 1'b1;
      step();
      sof = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (lup !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_in_frame cyc %0d: link_up %b want 0",
                     i, lup);
         end
         step();
      end
      eof = 1'b1;
      step();
      eof = 1'b0;
      n_chk++;
      if (lup !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_eof: link_up %b want 0", lup);
      end
      step();
      n_chk++;
      if (lup !== 1'b1 || abrt !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_idle_up: link_up %b abort %b want 1 0",
                  lup, abrt);
      end
   endtask

   task automatic test_counter_sat();
      clr = 1'b1;
      step();
      clr = 1'b0;
      n_chk++;
      if (ilf !== 1'b0 || irf !== 1'b0 || ild !== 1'b0 ||
          cnt !== 16'd0 || cnt2 !== 2'd0) begin
         n_fail++;
         $display("FAIL clear: ilf %b irf %b ild %b cnt %0d cnt2 %0d want 0",
                  ilf, irf, ild, cnt, cnt2);
      end
      for (int i = 0; i < 5; i++) begin
         loc = 1'b1;
         step();
         if (i == 0) begin
            n_chk++;
            if (abrt !== 1'b0 || ild !== 1'b1 || lup !== 1'b0) begin
               n_fail++;
               $display("FAIL down_no_frame: abort %b ild %b lup %b want 0 1 0",
                        abrt, ild, lup);
            end
         end
         loc = 1'b0;
         step();
      end
      n_chk++;
      if (cnt !== 16'd5 || cnt2 !== 2'd3) begin
         n_fail++;
         $display("FAIL cnt_sat: cnt %0d cnt2 %0d want 5 3", cnt, cnt2);
      end
      loc = 1'b1;
      clr = 1'b1;
      step();
      clr = 1'b0;
      loc = 1'b0;
      n_chk++;
      if (cnt !== 16'd1 || cnt2 !== 2'd1) begin
         n_fail++;
         $display("FAIL clr_edge_cnt: cnt %0d cnt2 %0d want 1 1",
                  cnt, cnt2);
      end
      n_chk++;
      if (ilf !== 1'b1 || irf !== 1'b0 || ild !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_edge_sticky: ilf %b irf %b ild %b want 1 0 0",
                  ilf, irf, ild);
      end
   endtask

   task automatic test_reset_mid_frame();
      idle = 1'b1;
      repeat (18) step();
      n_chk++;
      if (lup !== 1'b1) begin
         n_fail++;
         $display("FAIL relink: link_up %b want 1", lup);
      end
      sof = 1'b1;
      step();
      sof = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (outs() !== 8'h00 || cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %b cnt %0d want 00000000 cnt 0",
                  outs(), cnt);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++;
         if (abrt !== 1'b0 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_abort: abort %b en %b want 0 0",
                     abrt, en);
         end
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         n_chk++;
         if (lup !== 1'b0) begin
            n_fail++;
            $display("FAIL rerelease cyc %0d: link_up %b want 0", i, lup);
         end
      end
      step();
      n_chk++;
      if (lup !== 1'b1) begin
         n_fail++;
         $display("FAIL rerelease_up: link_up %b want 1", lup);
      end
   endtask

   initial begin
      test_reset();
      test_fault_abort();
      test_priority();
      test_glitch();
      test_counter_sat();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
